// File: rtl/cam_soc_pio_pkg.sv
// Shared constants for the camera SoC PIO stream block: Avalon register
// addresses, STATUS/CONTROL bit positions and a level-width helper.
package cam_soc_pio_pkg;

    // Avalon register addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // STATUS register bit positions
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_DRAINED   = 3;
    localparam int STAT_LEVEL_LSB = 8;

    // CONTROL register bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // Ceiling log2, used to size FIFO pointers; level is one bit wider.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cam_soc_pio_fifo.sv
// Synchronous FIFO for the PIO stream. Pushes into a full FIFO are accepted
// only when a pop happens in the same cycle; flush discards everything and
// wins over a simultaneous push. Head reads 0 while empty.
module cam_soc_pio_fifo
    import cam_soc_pio_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [clog2(DEPTH):0]  level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_pop_acc;
    logic             w_push_acc;

    assign empty      = (r_level == '0);
    assign full       = (r_level == (AW+1)'(DEPTH));
    assign level      = r_level;
    assign w_pop_acc  = pop & ~empty;
    assign w_push_acc = push & ~flush & (~full | w_pop_acc);
    assign head       = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array write
    // NOTE: the data array has no reset; only pointers/level define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and level bookkeeping; flush empties the FIFO outright
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/cam_soc_pio_stream.sv
// Avalon-MM PIO successor: DATA writes enqueue words that drain to hardware
// over valid/ready; out_port holds the last accepted word. Register decode,
// sticky flags and the out_port register live here.
// Optional feature: define CAM_SOC_PIO_IRQ_EN to add the drained flag,
// irq_en control bit and the irq output.
module cam_soc_pio_stream
    import cam_soc_pio_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_port
`ifdef CAM_SOC_PIO_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int LW = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_out_port;
    logic             r_enable;
    logic             r_overflow;
    logic             w_write;
    logic             w_wr_data;
    logic             w_wr_status;
    logic             w_wr_ctrl;
    logic             w_flush;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;
    logic [LW-1:0]    w_level;
    logic             w_unused_wdata;

    assign w_write        = chipselect & ~write_n;
    assign w_wr_data      = w_write & (address == ADDR_DATA);
    assign w_wr_status    = w_write & (address == ADDR_STATUS);
    assign w_wr_ctrl      = w_write & (address == ADDR_CTRL);
    assign w_flush        = w_wr_ctrl & writedata[CTRL_FLUSH];
    assign w_pop          = out_valid & out_ready;
    assign w_unused_wdata = ^writedata;

    assign out_valid = ~w_empty & r_enable;
    assign out_data  = w_head;
    assign out_port  = r_out_port;

    cam_soc_pio_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_wr_data),
        .wdata   (writedata[WIDTH-1:0]),
        .pop     (w_pop),
        .flush   (w_flush),
        .head    (w_head),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Capture the head word on every completed handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_port <= RESET_VALUE;
        end else if (w_pop) begin
            r_out_port <= w_head;
        end
    end

    // Enable bit and sticky overflow: a push into a full FIFO with no pop is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_enable <= writedata[CTRL_ENABLE];
            if (w_wr_data & ~w_flush & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status & writedata[STAT_OVERFLOW]) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef CAM_SOC_PIO_IRQ_EN
    logic r_irq_en;
    logic r_drained;

    // Drained flag sets when a real pop empties the FIFO (not a flush); set beats clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en  <= 1'b0;
            r_drained <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= writedata[CTRL_IRQ_EN];
            if (w_pop & ~w_flush & (w_level == LW'(1))) begin
                r_drained <= 1'b1;
            end else if (w_wr_status & writedata[STAT_DRAINED]) begin
                r_drained <= 1'b0;
            end
        end
    end

    assign irq = r_drained & r_irq_en;
`endif

    // Zero-wait-state register read mux; unused bits read 0
    // NOTE: readdata is given a full default first so no path through the case infers a latch.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = r_out_port;
            ADDR_STATUS: begin
                readdata[STAT_EMPTY]              = w_empty;
                readdata[STAT_FULL]               = w_full;
                readdata[STAT_OVERFLOW]           = r_overflow;
                readdata[STAT_LEVEL_LSB +: LW]    = w_level;
`ifdef CAM_SOC_PIO_IRQ_EN
                readdata[STAT_DRAINED]            = r_drained;
`endif
            end
            ADDR_CTRL: begin
                readdata[CTRL_ENABLE] = r_enable;
`ifdef CAM_SOC_PIO_IRQ_EN
                readdata[CTRL_IRQ_EN] = r_irq_en;
`endif
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cam_soc_pio_stream.sv
// Self-checking bench for cam_soc_pio_stream (WIDTH=16, DEPTH=4,
// RESET_VALUE=0xBEEF). Table of per-cycle vectors plus hand sequences for
// full push/pop, enable/flush, irq (when CAM_SOC_PIO_IRQ_EN) and async reset.
module tb_cam_soc_pio_stream;
    import cam_soc_pio_pkg::*;

    localparam logic [15:0] RV = 16'hBEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_port;
`ifdef CAM_SOC_PIO_IRQ_EN
    logic        irq;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cam_soc_pio_stream #(
        .WIDTH       (16),
        .DEPTH       (4),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_port   (out_port)
`ifdef CAM_SOC_PIO_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [15:0] exp_port;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                                input logic rdy, input logic [31:0] rd, input logic v,
                                input logic [15:0] d, input logic [15:0] p);
        vec_t t;
        t.addr = a; t.wr = wr; t.wdata = wd; t.rdy = rdy;
        t.exp_rd = rd; t.exp_valid = v; t.exp_data = d; t.exp_port = p;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic wr, input logic [31:0] wd, input logic rdy);
        address    = a;
        chipselect = 1'b1;
        write_n    = ~wr;
        writedata  = wd;
        out_ready  = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd, input logic rdy);
        drive(a, 1'b1, wd, rdy);
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic rdy, input logic [31:0] exp);
        drive(a, 1'b0, 32'h0, rdy);
        #1;
        check(name, readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // addr, wr, wdata, rdy | readdata, out_valid, out_data, out_port
        vecs.push_back(mk(ADDR_STATUS, 0, 32'h0,    0, 32'h1,    0, 16'h0,    RV));       // 0 reset status
        vecs.push_back(mk(ADDR_CTRL,   0, 32'h0,    0, 32'h1,    0, 16'h0,    RV));       // 1 reset ctrl
        vecs.push_back(mk(ADDR_DATA,   0, 32'h0,    0, 32'hBEEF, 0, 16'h0,    RV));       // 2 reset data
        vecs.push_back(mk(ADDR_DATA,   1, 32'hFFFFA5A5, 1, 32'hBEEF, 0, 16'h0, RV));      // 3 push A5A5
        vecs.push_back(mk(ADDR_STATUS, 0, 32'h0,    1, 32'h0100, 1, 16'hA5A5, RV));       // 4 valid, popped at edge
        vecs.push_back(mk(ADDR_DATA,   0, 32'h0,    1, 32'hA5A5, 0, 16'h0,    16'hA5A5)); // 5
        vecs.push_back(mk(ADDR_STATUS, 0, 32'h0,    0, 32'h1,    0, 16'h0,    16'hA5A5)); // 6
        vecs.push_back(mk(ADDR_DATA,   1, 32'h1,    0, 32'hA5A5, 0, 16'h0,    16'hA5A5)); // 7
        vecs.push_back(mk(ADDR_DATA,   1, 32'h2,    0, 32'hA5A5, 1, 16'h1,    16'hA5A5)); // 8
        vecs.push_back(mk(ADDR_DATA,   1, 32'h3,    0, 32'hA5A5, 1, 16'h1,    16'hA5A5)); // 9
        vecs.push_back(mk(ADDR_DATA,   1, 32'h4,    0, 32'hA5A5, 1, 16'h1,    16'hA5A5)); // 10
        vecs.push_back(mk(ADDR_DATA,   1, 32'h5,    0, 32'hA5A5, 1, 16'h1,    16'hA5A5)); // 11 dropped
        vecs.push_back(mk(ADDR_STATUS, 0, 32'h0,    0, 32'h0406, 1, 16'h1,    16'hA5A5)); // 12
        vecs.push_back(mk(ADDR_STATUS, 1, 32'h4,    0, 32'h0406, 1, 16'h1,    16'hA5A5)); // 13 clear ovf
        vecs.push_back(mk(ADDR_STATUS, 0, 32'h0,    0, 32'h0402, 1, 16'h1,    16'hA5A5)); // 14
        vecs.push_back(mk(ADDR_DATA,   0, 32'h0,    1, 32'hA5A5, 1, 16'h1,    16'hA5A5)); // 15 drain
        vecs.push_back(mk(ADDR_DATA,   0, 32'h0,    1, 32'h1,    1, 16'h2,    16'h1));    // 16
        vecs.push_back(mk(ADDR_DATA,   0, 32'h0,    1, 32'h2,    1, 16'h3,    16'h2));    // 17
        vecs.push_back(mk(ADDR_DATA,   0, 32'h0,    1, 32'h3,    1, 16'h4,    16'h3));    // 18
        vecs.push_back(mk(ADDR_DATA,   0, 32'h0,    1, 32'h4,    0, 16'h0,    16'h4));    // 19 empty, ready ignored
        vecs.push_back(mk(ADDR_STATUS, 0, 32'h0,    0, 32'h1,    0, 16'h0,    16'h4));    // 20
        vecs.push_back(mk(ADDR_RSVD,   1, 32'h0,    0, 32'h0,    0, 16'h0,    16'h4));    // 21 reserved write
        vecs.push_back(mk(ADDR_STATUS, 0, 32'h0,    0, 32'h1,    0, 16'h0,    16'h4));    // 22
        vecs.push_back(mk(ADDR_CTRL,   0, 32'h0,    0, 32'h1,    0, 16'h0,    16'h4));    // 23

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d readdata", i),  readdata,          vecs[i].exp_rd);
            check($sformatf("vec%0d out_valid", i), 32'(out_valid),    32'(vecs[i].exp_valid));
            check($sformatf("vec%0d out_data", i),  32'(out_data),     32'(vecs[i].exp_data));
            check($sformatf("vec%0d out_port", i),  32'(out_port),     32'(vecs[i].exp_port));
            tick();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        out_ready  = 1'b0;

        // Full FIFO: push concurrent with pop is accepted, no overflow
        begin
            logic [15:0] exp_seq [4];
            exp_seq[0] = 16'h22; exp_seq[1] = 16'h33; exp_seq[2] = 16'h44; exp_seq[3] = 16'h77;
            wr(ADDR_DATA, 32'h11, 1'b0);
            wr(ADDR_DATA, 32'h22, 1'b0);
            wr(ADDR_DATA, 32'h33, 1'b0);
            wr(ADDR_DATA, 32'h44, 1'b0);
            wr(ADDR_DATA, 32'h77, 1'b1);
            rd_check("full push+pop status", ADDR_STATUS, 1'b0, 32'h0402);
            check("full push+pop port", 32'(out_port), 32'h11);
            check("full push+pop head", 32'(out_data), 32'h22);
            for (int i = 0; i < 4; i++) begin
                drive(ADDR_STATUS, 1'b0, 32'h0, 1'b1);
                tick();
                check($sformatf("drain%0d port", i), 32'(out_port), 32'(exp_seq[i]));
            end
            rd_check("after drain status", ADDR_STATUS, 1'b0, 32'h1);
        end

        // enable=0 holds contents; flush during a pop
        wr(ADDR_CTRL, 32'h0, 1'b0);
        rd_check("disabled ctrl", ADDR_CTRL, 1'b0, 32'h0);
        wr(ADDR_DATA, 32'h5A, 1'b1);
        wr(ADDR_DATA, 32'h5B, 1'b1);
        rd_check("disabled status", ADDR_STATUS, 1'b1, 32'h0200);
        check("disabled valid", 32'(out_valid), 32'h0);
        tick();
        tick();
        check("disabled port held", 32'(out_port), 32'h77);
        check("disabled valid held", 32'(out_valid), 32'h0);
        wr(ADDR_CTRL, 32'h1, 1'b0);
        check("reenabled valid", 32'(out_valid), 32'h1);
        check("reenabled head", 32'(out_data), 32'h5A);
        wr(ADDR_CTRL, 32'h3, 1'b1);
        rd_check("flush+pop status", ADDR_STATUS, 1'b0, 32'h1);
        check("flush+pop port", 32'(out_port), 32'h5A);
        check("flush+pop valid", 32'(out_valid), 32'h0);
        rd_check("flush reads 0", ADDR_CTRL, 1'b0, 32'h1);

`ifdef CAM_SOC_PIO_IRQ_EN
        wr(ADDR_CTRL, 32'h5, 1'b0);
        check("irq idle", 32'(irq), 32'h0);
        rd_check("irq_en ctrl", ADDR_CTRL, 1'b0, 32'h5);
        wr(ADDR_DATA, 32'h99, 1'b1);
        tick();
        check("irq after drain", 32'(irq), 32'h1);
        rd_check("drained status", ADDR_STATUS, 1'b0, 32'h9);
        check("drained port", 32'(out_port), 32'h99);
        wr(ADDR_STATUS, 32'h8, 1'b0);
        check("irq cleared", 32'(irq), 32'h0);
        rd_check("drained cleared", ADDR_STATUS, 1'b0, 32'h1);
        wr(ADDR_DATA, 32'h1, 1'b0);
        wr(ADDR_DATA, 32'h2, 1'b0);
        wr(ADDR_CTRL, 32'h7, 1'b0);
        check("irq after flush", 32'(irq), 32'h0);
        rd_check("flush status", ADDR_STATUS, 1'b0, 32'h1);
        wr(ADDR_DATA, 32'h3, 1'b0);
        wr(ADDR_CTRL, 32'h7, 1'b1);
        check("irq after flush+pop", 32'(irq), 32'h0);
        check("flush+pop last port", 32'(out_port), 32'h3);
        rd_check("flush+pop last status", ADDR_STATUS, 1'b0, 32'h1);
`else
        wr(ADDR_CTRL, 32'h5, 1'b0);
        rd_check("irq_en ignored", ADDR_CTRL, 1'b0, 32'h1);
        wr(ADDR_DATA, 32'h99, 1'b1);
        tick();
        rd_check("no drained bit", ADDR_STATUS, 1'b0, 32'h1);
        check("single pop port", 32'(out_port), 32'h99);
`endif

        // Asynchronous reset in the middle of a pending handshake
        wr(ADDR_DATA, 32'h4242, 1'b0);
        drive(ADDR_STATUS, 1'b0, 32'h0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset valid", 32'(out_valid), 32'h0);
        check("async reset data", 32'(out_data), 32'h0);
        check("async reset port", 32'(out_port), 32'(RV));
        check("async reset status", readdata, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        rd_check("post reset status", ADDR_STATUS, 1'b0, 32'h1);
        check("post reset port", 32'(out_port), 32'(RV));
        rd_check("post reset ctrl", ADDR_CTRL, 1'b0, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
